lsu_icb_rspd: RTL and testbench

- ICB responder at the LSU end of the AGU command interface.
- Accepts one AGU command at a time (addr/read/wdata/wmask) and forwards it to a single-port data-memory request/response bus.
- Returns read data, or a write completion, to the AGU on the ICB response channel. Carries an error flag for memory errors and response timeouts.
- Sits between exu_alu's AGU path and the data memory or DPI memory model.

---
 rtl/lsu_icb_rspd_pkg.sv | 21 ++
 rtl/lsu_icb_tocnt.sv | 28 ++
 rtl/lsu_icb_rspd.sv | 160 ++++++++++++++++
 tb/tb_lsu_icb_rspd.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_icb_rspd_pkg.sv
// Shared definitions for the LSU ICB responder: default widths and FSM state encoding.
package lsu_icb_rspd_pkg;

  localparam int unsigned LSU_XLEN        = 32;
  localparam int unsigned LSU_ADDR_SIZE   = 32;
  localparam int unsigned LSU_TIMEOUT_CYC = 255;
  localparam int unsigned LSU_ST_W        = 2;

  typedef enum logic [LSU_ST_W-1:0] {
    LSU_ST_IDLE = 2'd0,
    LSU_ST_REQ  = 2'd1,
    LSU_ST_WAIT = 2'd2,
    LSU_ST_RSP  = 2'd3
  } lsu_st_e;

  // A store with no byte enabled completes without touching memory.
  function automatic logic is_null_store(input logic read, input logic any_mask);
    return !read && !any_mask;
  endfunction

endpackage

// File: rtl/lsu_icb_tocnt.sv
// Saturating WAIT-state timeout counter; expire_c flags the last allowed wait cycle.
module lsu_icb_tocnt #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/lsu_icb_rspd.sv
// ICB responder at the LSU end of the AGU command interface: one command at a time,
// forwarded to a single-port data-memory bus, answered on the ICB response channel.
module lsu_icb_rspd
  import lsu_icb_rspd_pkg::*;
#(
  parameter int unsigned XLEN        = LSU_XLEN,
  parameter int unsigned ADDR_SIZE   = LSU_ADDR_SIZE,
  parameter int unsigned TIMEOUT_CYC = LSU_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 agu_icb_cmd_valid,
  output logic                 agu_icb_cmd_ready,
  input  logic [ADDR_SIZE-1:0] agu_icb_cmd_addr,
  input  logic                 agu_icb_cmd_read,
  input  logic [XLEN-1:0]      agu_icb_cmd_wdata,
  input  logic [XLEN/8-1:0]    agu_icb_cmd_wmask,
  output logic                 agu_icb_rsp_valid,
  input  logic                 agu_icb_rsp_ready,
  output logic [XLEN-1:0]      agu_icb_rsp_rdata,
  output logic                 agu_icb_rsp_err,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDR_SIZE-1:0] mem_req_addr,
  output logic                 mem_req_wen,
  output logic [XLEN-1:0]      mem_req_wdata,
  output logic [XLEN/8-1:0]    mem_req_wmask,
  input  logic                 mem_rsp_valid,
  input  logic [XLEN-1:0]      mem_rsp_rdata,
  input  logic                 mem_rsp_err
);

  localparam int unsigned MASK_W = XLEN / 8;

  lsu_st_e state_q;
  lsu_st_e state_d;

  logic cmd_ready_c;
  logic rsp_valid_c;
  logic req_valid_c;
  logic cmd_fire;
  logic rsp_capture;
  logic rsp_timeout;
  logic cnt_clr;
  logic cnt_inc;
  logic cnt_expire_c;

  logic [ADDR_SIZE-1:0] addr_q;
  logic                 wen_q;
  logic [XLEN-1:0]      wdata_q;
  logic [MASK_W-1:0]    wmask_q;
  logic [XLEN-1:0]      rsp_rdata_q;
  logic                 rsp_err_q;

  // Byte-lane offset is the AGU's concern; only the word address goes to memory.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^agu_icb_cmd_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LSU_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_ST_IDLE: begin
        if (agu_icb_cmd_valid) begin
          state_d = is_null_store(agu_icb_cmd_read, |agu_icb_cmd_wmask) ? LSU_ST_RSP : LSU_ST_REQ;
        end
      end
      LSU_ST_REQ:  if (mem_req_ready) state_d = LSU_ST_WAIT;
      LSU_ST_WAIT: if (mem_rsp_valid || cnt_expire_c) state_d = LSU_ST_RSP;
      LSU_ST_RSP:  if (agu_icb_rsp_ready) state_d = LSU_ST_IDLE;
      default:     state_d = LSU_ST_IDLE;
    endcase
  end

  // Handshake and datapath controls decoded from the current state.
  always_comb begin
    cmd_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    req_valid_c = 1'b0;
    cmd_fire    = 1'b0;
    rsp_capture = 1'b0;
    rsp_timeout = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      LSU_ST_IDLE: begin
        cmd_ready_c = 1'b1;
        cmd_fire    = agu_icb_cmd_valid;
      end
      LSU_ST_REQ: begin
        req_valid_c = 1'b1;
        cnt_clr     = mem_req_ready;
      end
      LSU_ST_WAIT: begin
        rsp_capture = mem_rsp_valid;
        rsp_timeout = !mem_rsp_valid && cnt_expire_c;
        cnt_inc     = !mem_rsp_valid;
      end
      LSU_ST_RSP: begin
        rsp_valid_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr_q      <= {agu_icb_cmd_addr[ADDR_SIZE-1:2], 2'b00};
        wen_q       <= !agu_icb_cmd_read;
        wdata_q     <= agu_icb_cmd_wdata;
        wmask_q     <= agu_icb_cmd_read ? {MASK_W{1'b1}} : agu_icb_cmd_wmask;
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b0;
      end
      if (rsp_capture) begin
        rsp_rdata_q <= wen_q ? '0 : mem_rsp_rdata;
        rsp_err_q   <= mem_rsp_err;
      end else if (rsp_timeout) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
      end
    end
  end

  lsu_icb_tocnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tocnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .expire_c (cnt_expire_c)
  );

  assign agu_icb_cmd_ready = cmd_ready_c;
  assign agu_icb_rsp_valid = rsp_valid_c;
  assign agu_icb_rsp_rdata = rsp_rdata_q;
  assign agu_icb_rsp_err   = rsp_err_q;
  assign mem_req_valid     = req_valid_c;
  assign mem_req_addr      = addr_q;
  assign mem_req_wen       = wen_q;
  assign mem_req_wdata     = wdata_q;
  assign mem_req_wmask     = wmask_q;

endmodule

// File: tb/tb_lsu_icb_rspd.sv
// Directed bench for lsu_icb_rspd: transaction-level model compared every cycle, plus literal checks.
module tb_lsu_icb_rspd;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ADDR_SIZE = 32;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_read = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wmask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;
  logic        mem_rsp_err = 1'b0;

  int n_tot = 0;
  int n_pass = 0;

  lsu_icb_rspd #(
    .XLEN(XLEN),
    .ADDR_SIZE(ADDR_SIZE),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .agu_icb_cmd_valid(cmd_valid),
    .agu_icb_cmd_ready(cmd_ready),
    .agu_icb_cmd_addr(cmd_addr),
    .agu_icb_cmd_read(cmd_read),
    .agu_icb_cmd_wdata(cmd_wdata),
    .agu_icb_cmd_wmask(cmd_wmask),
    .agu_icb_rsp_valid(rsp_valid),
    .agu_icb_rsp_ready(rsp_ready),
    .agu_icb_rsp_rdata(rsp_rdata),
    .agu_icb_rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_err(mem_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: one command in flight; a request, a wait for memory, then a response.
  bit          m_busy, m_req, m_wait, m_rsp;
  int          m_wn;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_wmask;
  logic        e_wen, e_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_req <= 0; m_wait <= 0; m_rsp <= 0; m_wn <= 0;
      e_addr <= '0; e_wdata <= '0; e_rdata <= '0; e_wmask <= '0; e_wen <= 1'b0; e_err <= 1'b0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy  <= 1;
        e_addr  <= cmd_addr & 32'hFFFF_FFFC;
        e_wen   <= !cmd_read;
        e_wdata <= cmd_wdata;
        e_wmask <= cmd_read ? 4'hF : cmd_wmask;
        if (!cmd_read && cmd_wmask == 4'h0) begin
          m_rsp <= 1; e_rdata <= '0; e_err <= 1'b0;
        end else begin
          m_req <= 1;
        end
      end
    end else if (m_req) begin
      if (mem_req_ready) begin m_req <= 0; m_wait <= 1; m_wn <= 0; end
    end else if (m_wait) begin
      if (mem_rsp_valid) begin
        m_wait <= 0; m_rsp <= 1;
        e_rdata <= e_wen ? 32'h0 : mem_rsp_rdata;
        e_err <= mem_rsp_err;
      end else if (m_wn + 1 == int'(TO)) begin
        m_wait <= 0; m_rsp <= 1; e_rdata <= '0; e_err <= 1'b1;
      end else begin
        m_wn <= m_wn + 1;
      end
    end else if (m_rsp && rsp_ready) begin
      m_rsp <= 0; m_busy <= 0;
    end
  end

  always @(negedge clk) begin
    chk("m_cmd_ready", 32'(cmd_ready), 32'(!m_busy));
    chk("m_req_valid", 32'(mem_req_valid), 32'(m_req));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(m_rsp));
    if (m_req) begin
      chk("m_req_addr", mem_req_addr, e_addr);
      chk("m_req_wen", 32'(mem_req_wen), 32'(e_wen));
      chk("m_req_wmask", 32'(mem_req_wmask), 32'(e_wmask));
      if (e_wen) chk("m_req_wdata", mem_req_wdata, e_wdata);
    end
    if (m_rsp) begin
      chk("m_rsp_rdata", rsp_rdata, e_rdata);
      chk("m_rsp_err", 32'(rsp_err), 32'(e_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_req_addr"}, mem_req_addr, 32'd0);
    chk({tag, "_req_wen"}, 32'(mem_req_wen), 32'd0);
    chk({tag, "_req_wdata"}, mem_req_wdata, 32'd0);
    chk({tag, "_req_wmask"}, 32'(mem_req_wmask), 32'd0);
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic rd, input logic [31:0] wd, input logic [3:0] wm);
    cmd_valid = 1'b1; cmd_addr = a; cmd_read = rd; cmd_wdata = wd; cmd_wmask = wm;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    step();
    step();
    chk_reset_outputs("rst");
    rst = 1'b0;
    step();

    // Load with minimum latency.
    mem_req_ready = 1'b1;
    send_cmd(32'h8000_0104, 1'b1, 32'h0, 4'h0);
    chk("ld_req_valid", 32'(mem_req_valid), 32'd1);
    chk("ld_req_addr", mem_req_addr, 32'h8000_0104);
    chk("ld_req_wmask", 32'(mem_req_wmask), 32'hF);
    chk("ld_req_wen", 32'(mem_req_wen), 32'd0);
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEAD_BEEF;
    step();
    mem_rsp_valid = 1'b0;
    chk("ld_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ld_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("ld_rsp_err", 32'(rsp_err), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("ld_done_cmd_ready", 32'(cmd_ready), 32'd1);

    // Store byte with request stalled four cycles.
    send_cmd(32'h8000_0203, 1'b0, 32'hAB00_0000, 4'h8);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) mem_req_ready = 1'b1;
      chk("st_req_valid", 32'(mem_req_valid), 32'd1);
      chk("st_req_addr", mem_req_addr, 32'h8000_0200);
      chk("st_req_wen", 32'(mem_req_wen), 32'd1);
      chk("st_req_wdata", mem_req_wdata, 32'hAB00_0000);
      chk("st_req_wmask", 32'(mem_req_wmask), 32'h8);
      step();
    end
    mem_req_ready = 1'b0;
    chk("st_req_dropped", 32'(mem_req_valid), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1234_5678;
    step();
    mem_rsp_valid = 1'b0;
    chk("st_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("st_rsp_rdata", rsp_rdata, 32'd0);
    chk("st_rsp_err", 32'(rsp_err), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Zero-mask store completes without a memory access.
    send_cmd(32'h0000_0040, 1'b0, 32'h5555_5555, 4'h0);
    chk("zm_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("zm_req_valid", 32'(mem_req_valid), 32'd0);
    chk("zm_rsp_err", 32'(rsp_err), 32'd0);
    chk("zm_rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Timeout after TO wait cycles, then a late response.
    mem_req_ready = 1'b1;
    send_cmd(32'h0000_1000, 1'b1, 32'h0, 4'h0);
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < int'(TO); i++) begin
      chk("to_waiting", 32'(rsp_valid), 32'd0);
      step();
    end
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFF_0000;
    step();
    mem_rsp_valid = 1'b0;
    chk("to_late_rdata", rsp_rdata, 32'd0);
    chk("to_late_err", 32'(rsp_err), 32'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    chk("stray_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);

    // Response backpressure with a memory error.
    mem_req_ready = 1'b1;
    send_cmd(32'h0000_2002, 1'b1, 32'h0, 4'h0);
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFE_F00D; mem_rsp_err = 1'b1;
    step();
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
      chk("bp_rsp_err", 32'(rsp_err), 32'd1);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_cmd_ready_after", 32'(cmd_ready), 32'd1);

    // Asynchronous reset while waiting on memory.
    mem_req_ready = 1'b1;
    send_cmd(32'h0000_3000, 1'b1, 32'h0, 4'h0);
    step();
    mem_req_ready = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("arst");
    @(posedge clk);
    #1 rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0BAD_0BAD;
    step();
    mem_rsp_valid = 1'b0;
    chk("arst_late_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("arst_late_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_late_rdata", rsp_rdata, 32'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
